// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit feeder.
//   tx_state_e    : launch FSM states
//   ASCII_CR/LF   : bytes used by the optional CR-before-LF insertion
//   DEFAULT_DEPTH : default FIFO depth (power of two, >= 2)
package uart_pkg;

  localparam int unsigned DEFAULT_DEPTH = 16;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   push, din       : enqueue din (accepted when not full, or when full with a pop)
//   pop, dout       : dequeue; dout always shows the head entry
//   count           : occupancy 0..DEPTH
//   full, empty     : decoded from the registered occupancy
module sync_fifo #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  // A pop on a full FIFO frees the slot this cycle, so a concurrent push is taken.
  always_comb begin
    pop_ok   = pop && (count_q != '0);
    push_ok  = push && ((count_q != (AW+1)'(DEPTH)) || pop_ok);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launch FSM feeding a UART transmitter one byte at a time.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   wr_en, wr_data    : CPU-side byte push
//   full, empty, count: FIFO status (count is 0..DEPTH)
//   ovf, ovf_clr      : sticky write-while-full flag and its clear
//   tx_idle           : FIFO empty and launch FSM idle
//   tx_start, tx_data : one-cycle launch pulse and the byte it carries
//   tx_busy           : transmitter busy flag
// Optional: define UART_TX_FEEDER_CRLF_EN to send CR ahead of every LF.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter  int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count,
  output logic        ovf,
  input  logic        ovf_clr,
  output logic        tx_idle,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy
);

  tx_state_e   state_q, state_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        ovf_q, ovf_d;
  logic        fifo_pop;
  logic [7:0]  fifo_dout;
`ifdef UART_TX_FEEDER_CRLF_EN
  logic        crlf_pend_q, crlf_pend_d;
`endif

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .pop   (fifo_pop),
    .din   (wr_data),
    .dout  (fifo_dout),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Launch FSM, overflow flag and optional CR insertion.
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    fifo_pop   = 1'b0;
`ifdef UART_TX_FEEDER_CRLF_EN
    crlf_pend_d = crlf_pend_q;
`endif

    case (state_q)
      IDLE: begin
        if (!empty && !tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = WAIT_BUSY;
`ifdef UART_TX_FEEDER_CRLF_EN
          // LF stays queued while its CR goes out first.
          if ((fifo_dout == ASCII_LF) && !crlf_pend_q) begin
            tx_data_d   = ASCII_CR;
            crlf_pend_d = 1'b1;
          end else begin
            fifo_pop    = 1'b1;
            tx_data_d   = fifo_dout;
            crlf_pend_d = 1'b0;
          end
`else
          fifo_pop  = 1'b1;
          tx_data_d = fifo_dout;
`endif
        end
      end
      WAIT_BUSY: if (tx_busy)  state_d = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    // Set beats clear; a write popped-through on a full FIFO is not an overflow.
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (wr_en && full && !fifo_pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef UART_TX_FEEDER_CRLF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) crlf_pend_q <= 1'b0;
    else     crlf_pend_q <= crlf_pend_d;
  end
`endif

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign ovf      = ovf_q;
  assign tx_idle  = empty && (state_q == IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_uart_tx_feeder;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
`ifdef UART_TX_FEEDER_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        ovf_clr = 1'b0;
  logic        full, empty, ovf, tx_idle, tx_start;
  logic [AW:0] count;
  logic [7:0]  tx_data;
  logic        tx_busy;

  // Transmitter model: manual level or automatic busy-after-start.
  logic        man_busy = 1'b0;
  logic        auto_busy = 1'b0;
  logic        auto_q = 1'b0;
  int          busy_len = 3;
  bit          rand_len = 1'b0;
  int          busy_cnt = 0;
  assign tx_busy = auto_busy ? auto_q : man_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] m_q[$];
  int         m_phase = 0;   // 0 ready, 1 launched, 2 transmitter busy
  bit         m_ovf = 1'b0, m_start = 1'b0, m_cr_sent = 1'b0;
  logic [7:0] m_data = 8'h00;

  logic [7:0] tx_log[$];

  always #5 clk = ~clk;

  uart_tx_feeder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .ovf(ovf), .ovf_clr(ovf_clr),
    .tx_idle(tx_idle), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: inputs are stable at the edge (driven 2 time units after it).
  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_phase = 0; m_ovf = 0; m_start = 0; m_data = 8'h00; m_cr_sent = 0;
    end else begin
      m_start = 1'b0;
      if (m_phase == 0) begin
        if (m_q.size() > 0 && !tx_busy) begin
          m_start = 1'b1;
          m_phase = 1;
          if (CRLF && m_q[0] == 8'h0A && !m_cr_sent) begin
            m_data = 8'h0D;
            m_cr_sent = 1'b1;
          end else begin
            m_data = m_q.pop_front();
            m_cr_sent = 1'b0;
          end
        end
      end else if (m_phase == 1) begin
        if (tx_busy) m_phase = 2;
      end else if (!tx_busy) begin
        m_phase = 0;
      end
      if (ovf_clr) m_ovf = 1'b0;
      if (wr_en) begin
        if (m_q.size() < DEPTH) m_q.push_back(wr_data);
        else m_ovf = 1'b1;
      end
    end
  end

  // Per-cycle compare against the model, and launch logging.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("count",    32'(count),    32'(m_q.size()));
      chk("empty",    32'(empty),    32'(m_q.size() == 0));
      chk("full",     32'(full),     32'(m_q.size() == DEPTH));
      chk("ovf",      32'(ovf),      32'(m_ovf));
      chk("tx_start", 32'(tx_start), 32'(m_start));
      chk("tx_data",  32'(tx_data),  32'(m_data));
      chk("tx_idle",  32'(tx_idle),  32'(m_q.size() == 0 && m_phase == 0));
      if (tx_start === 1'b1) tx_log.push_back(tx_data);
    end
  end

  // Automatic transmitter: busy for a chosen number of cycles after each start.
  always @(posedge clk) begin
    #2;
    if (auto_busy) begin
      if (tx_start === 1'b1) begin
        auto_q   = 1'b1;
        busy_cnt = rand_len ? int'($urandom_range(1, 12)) : busy_len;
      end else if (busy_cnt > 1) begin
        busy_cnt--;
      end else if (busy_cnt == 1) begin
        busy_cnt = 0;
        auto_q   = 1'b0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic burst(input logic [7:0] base, input int n);
    @(posedge clk); #2;
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1;
      wr_data = base + 8'(i);
      @(posedge clk); #2;
    end
    wr_en = 1'b0;
  endtask

  task automatic drain(input int limit);
    int c;
    c = 0;
    while (!(tx_idle === 1'b1 && tx_busy === 1'b0) && c < limit) begin
      cyc(1);
      c++;
    end
    chk("drain_timeout", 32'(c < limit), 32'd1);
  endtask

  task automatic check_log(input string name, input bq_t exp);
    chk({name, "_len"}, 32'(tx_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < tx_log.size(); i++)
      chk(name, 32'(tx_log[i]), 32'(exp[i]));
  endtask

  function automatic bq_t expand(input bq_t in);
    bq_t out;
    foreach (in[i]) begin
      if (CRLF && in[i] == 8'h0A) out.push_back(8'h0D);
      out.push_back(in[i]);
    end
    return out;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t exp;
    int  c;

    // Reset values
    cyc(3);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_ovf",   32'(ovf),   32'd0);
    chk("rst_start", 32'(tx_start), 32'd0);
    chk("rst_data",  32'(tx_data),  32'd0);
    chk("rst_idle",  32'(tx_idle),  32'd1);
    rst = 1'b0;
    cyc(2);

    // 1: single byte, launch latency, idle after busy falls
    auto_busy = 1'b1; busy_len = 10; tx_log.delete();
    burst(8'h41, 1);
    chk("t1_no_start_yet", 32'(tx_start), 32'd0);
    chk("t1_count1", 32'(count), 32'd1);
    cyc(1);
    chk("t1_start", 32'(tx_start), 32'd1);
    chk("t1_data",  32'(tx_data),  32'h41);
    cyc(1);
    chk("t1_pulse_one_cycle", 32'(tx_start), 32'd0);
    c = 0;
    while (tx_busy === 1'b1 && c < 30) begin cyc(1); c++; end
    chk("t1_busy_fall", 32'(c < 30), 32'd1);
    cyc(1);
    chk("t1_idle", 32'(tx_idle), 32'd1);
    chk("t1_data_hold", 32'(tx_data), 32'h41);
    chk("t1_launches", 32'(tx_log.size()), 32'd1);

    // 2: burst to full, overflow, in-order drain, ovf clear
    auto_busy = 1'b0; man_busy = 1'b1; tx_log.delete();
    burst(8'h00, 16);
    chk("t2_full",  32'(full),  32'd1);
    chk("t2_count", 32'(count), 32'd16);
    burst(8'hAA, 1);
    chk("t2_ovf",   32'(ovf),   32'd1);
    chk("t2_count_kept", 32'(count), 32'd16);
    man_busy = 1'b0; auto_busy = 1'b1; busy_len = 3;
    drain(600);
    exp.delete();
    for (int i = 0; i < 16; i++) exp.push_back(8'(i));
    check_log("t2_order", expand(exp));
    chk("t2_ovf_sticky", 32'(ovf), 32'd1);
    ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0;
    chk("t2_ovf_clr", 32'(ovf), 32'd0);

    // 3: push on full with simultaneous pop
    auto_busy = 1'b0; man_busy = 1'b1; tx_log.delete();
    burst(8'h10, 16);
    chk("t3_full", 32'(full), 32'd1);
    auto_busy = 1'b1; busy_len = 2;
    wr_en = 1'b1; wr_data = 8'h55;
    cyc(1);
    wr_en = 1'b0;
    chk("t3_start",  32'(tx_start), 32'd1);
    chk("t3_count",  32'(count),    32'd16);
    chk("t3_no_ovf", 32'(ovf),      32'd0);
    drain(600);
    exp.delete();
    for (int i = 0; i < 16; i++) exp.push_back(8'h10 + 8'(i));
    exp.push_back(8'h55);
    check_log("t3_order", exp);

    // 4: reset while waiting for busy to fall, transmitter still busy after
    auto_busy = 1'b0; man_busy = 1'b1; tx_log.delete();
    burst(8'h60, 6);
    chk("t4_count6", 32'(count), 32'd6);
    man_busy = 1'b0;
    cyc(1);
    chk("t4_start", 32'(tx_start), 32'd1);
    chk("t4_count5", 32'(count), 32'd5);
    man_busy = 1'b1;
    cyc(3);
    chk("t4_busy_wait", 32'(tx_idle), 32'd0);
    rst = 1'b1;
    #1;
    chk("t4_rst_count", 32'(count),    32'd0);
    chk("t4_rst_empty", 32'(empty),    32'd1);
    chk("t4_rst_start", 32'(tx_start), 32'd0);
    chk("t4_rst_idle",  32'(tx_idle),  32'd1);
    cyc(1);
    rst = 1'b0;
    tx_log.delete();
    cyc(20);
    chk("t4_no_start_busy", 32'(tx_log.size()), 32'd0);
    man_busy = 1'b0;
    cyc(5);
    chk("t4_no_start_empty", 32'(tx_log.size()), 32'd0);
    auto_busy = 1'b1; busy_len = 4;
    burst(8'h77, 1);
    drain(100);
    exp.delete(); exp.push_back(8'h77);
    check_log("t4_new", exp);

    // 5: LF handling
    tx_log.delete(); busy_len = 3;
    burst(8'h48, 1);
    burst(8'h0A, 1);
    drain(200);
    exp.delete();
    if (CRLF) begin exp.push_back(8'h48); exp.push_back(8'h0D); exp.push_back(8'h0A); end
    else      begin exp.push_back(8'h48); exp.push_back(8'h0A); end
    check_log("t5_seq", exp);

    // 6: pointer wrap with random busy lengths
    tx_log.delete(); rand_len = 1'b1; exp.delete();
    for (int i = 0; i < 40; i++) begin
      c = 0;
      while (m_q.size() >= DEPTH - 1 && c < 200) begin cyc(1); c++; end
      burst(8'h20 + 8'(i), 1);
      exp.push_back(8'h20 + 8'(i));
      cyc(int'($urandom_range(0, 3)));
    end
    drain(3000);
    check_log("t6_order", exp);
    chk("t6_ovf",   32'(ovf),   32'd0);
    chk("t6_count", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
